// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: generic valid/ready pipeline stage register.
// Flush drops every held and incoming entry and presents NOP_VALUE as a bubble.
// A saturating counter records the cycles in which the output is stalled.
// Optional feature macro PIPE_SKID_STAGE_SKID_EN adds a second (skid) entry.
// With the skid entry, in_ready becomes a register output and has no
// combinational path from out_ready. The default build has one entry.
module pipe_skid_stage #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = {DATA_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q,  stall_cnt_d;
  logic                  accept;

  assign accept    = in_valid && in_ready;
  assign out_valid = main_valid_q;
  // Gate the held payload so downstream never sees stale data in a bubble.
  assign out_data  = main_valid_q ? main_data_q : NOP_VALUE;
  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_SKID_STAGE_SKID_EN
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;

  // in_ready depends only on skid occupancy, so it has no path from out_ready.
  assign in_ready = !skid_valid_q;

  // Next state for the main and skid entries. The skid entry only fills when
  // the main entry is blocked, and it drains into the main entry first.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_VALUE;
      skid_valid_d = 1'b0;
      skid_data_d  = NOP_VALUE;
    end else if (skid_valid_q) begin
      // Full: in_ready is 0, so nothing new can arrive this cycle.
      if (out_ready) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q && !out_ready) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else begin
      // The main entry is empty or emitting, so a new payload replaces it.
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end
  end

  // Skid entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VALUE;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Single entry: the stage can take a payload when empty or draining.
  assign in_ready = !main_valid_q || out_ready;

  // Next state for the single entry. An accept during an emit replaces the entry.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_VALUE;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  // Saturating stall counter. Flush does not touch it; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Main entry and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VALUE;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: table-driven vectors plus hand-written
// sequences for saturation and asynchronous reset.
module tb_pipe_skid_stage;
  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] NOP = 16'hDEAD;
`ifdef PIPE_SKID_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_sc;
  } vec_t;

  vec_t vecs[$];

  pipe_skid_stage #(.DATA_WIDTH(DW), .NOP_VALUE(NOP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, then check outputs.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    flush = v.fl; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #1;
    chk({tag, ".in_ready"},  {15'd0, in_ready},  {15'd0, v.e_ir});
    chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v.e_ov});
    chk({tag, ".out_data"},  out_data,           v.e_od);
    chk({tag, ".stall_cnt"}, {12'd0, stall_cnt}, {12'd0, v.e_sc});
  endtask

  function automatic vec_t mk(logic fl, logic iv, logic [15:0] id, logic ordy,
                              logic e_ir, logic e_ov, logic [15:0] e_od, logic [3:0] e_sc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_sc = e_sc;
    return v;
  endfunction

  initial begin
    // Stream 1..8 with out_ready held high; output lags by one cycle.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1, 16'(i), 1, 1, i > 1, (i > 1) ? 16'(i - 1) : NOP, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 16'h8, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, NOP, 0));
    // Backpressure: 0xA held for 3 cycles while 0xB waits (or sits in skid).
    vecs.push_back(mk(0, 1, 16'hA, 1, 1, 0, NOP, 0));
    vecs.push_back(mk(0, 1, 16'hB, 0, SKID, 1, 16'hA, 0));
    vecs.push_back(mk(0, 1, 16'hB, 0, 0, 1, 16'hA, 1));
    vecs.push_back(mk(0, 1, 16'hB, 0, 0, 1, 16'hA, 2));
    // Flush with occupancy and a concurrent 0xC offer: 0xC must be dropped.
    vecs.push_back(mk(1, 1, 16'hC, 1, 1 - SKID, 1, 16'hA, 3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, NOP, 3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, NOP, 3));
    // Single-cycle ready drop: A then B, nothing lost or duplicated.
    vecs.push_back(mk(0, 1, 16'hA, 1, 1, 0, NOP, 3));
    vecs.push_back(mk(0, 1, 16'hB, 0, SKID, 1, 16'hA, 3));
    vecs.push_back(mk(0, SKID ? 1'b0 : 1'b1, 16'hB, 1, 1 - SKID, 1, 16'hA, 4));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 16'hB, 4));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, NOP, 4));
    // Simultaneous accept and emit: 5 then 6 with no bubble in between.
    vecs.push_back(mk(0, 1, 16'h5, 1, 1, 0, NOP, 4));
    vecs.push_back(mk(0, 1, 16'h6, 1, 1, 1, 16'h5, 4));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 16'h6, 4));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, NOP, 4));

    reset = 1'b1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    #12;
    chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst.out_data",  out_data, NOP);
    chk("rst.stall_cnt", {12'd0, stall_cnt}, 16'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Saturation: stall 20 cycles, the counter climbs from 4 and holds at 15.
    apply(mk(0, 1, 16'h7, 1, 1, 0, NOP, 4), "sat.load");
    for (int i = 0; i < 20; i++)
      apply(mk(0, 0, 0, 0, SKID ? 1'b1 : 1'b0, 1, 16'h7, (4 + i > 15) ? 4'd15 : 4'(4 + i)),
            $sformatf("sat%0d", i));
    apply(mk(1, 0, 0, 0, SKID ? 1'b1 : 1'b0, 1, 16'h7, 15), "sat.flush");
    apply(mk(0, 0, 0, 1, 1, 0, NOP, 15), "sat.after");

    // Asynchronous reset while stalled, between clock edges.
    apply(mk(0, 1, 16'h9, 1, 1, 0, NOP, 15), "ar.load");
    apply(mk(0, 0, 0, 0, SKID ? 1'b1 : 1'b0, 1, 16'h9, 15), "ar.stall");
    #1 reset = 1'b1;
    #1;
    chk("ar.out_valid", {15'd0, out_valid}, 16'd0);
    chk("ar.out_data",  out_data, NOP);
    chk("ar.stall_cnt", {12'd0, stall_cnt}, 16'd0);
    @(negedge clk); reset = 1'b0;
    apply(mk(0, 0, 0, 0, 1, 0, NOP, 0), "ar.post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
